// File: rtl/wb_pkg.sv
// Shared definitions for the writeback retire queue: op bit positions, divider
// result fields and the queue entry layout.
package wb_pkg;

  localparam int unsigned OP_MULT     = 15;
  localparam int unsigned OP_DIV      = 14;
  localparam int unsigned OP_HIWRITE  = 12;
  localparam int unsigned OP_LOWRITE  = 11;
  localparam int unsigned OP_REGWRITE = 10;

  localparam int unsigned DIV_Q_HI = 71;
  localparam int unsigned DIV_Q_LO = 40;
  localparam int unsigned DIV_R_HI = 31;
  localparam int unsigned DIV_R_LO = 0;

  // Slots hold the op vector zero-extended to this width so OP_W may vary up to it.
  localparam int unsigned OP_MAX_W = 32;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic [OP_MAX_W-1:0] op;
    logic [4:0]          dest;
    logic [31:0]         value;
    logic [3:0]          be;
  } wb_entry_t;

endpackage

// File: rtl/wb_hilo_sel.sv
// HI/LO write-data selection: multiplier product, divider result or the
// entry's own value.
module wb_hilo_sel (
  input  logic        is_mult,
  input  logic        is_div,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [31:0] value,
  output logic [31:0] wd_hi,
  output logic [31:0] wd_lo
);

  always_comb begin
    wd_hi = value;
    wd_lo = value;
    if (is_mult) begin
      wd_hi = mult_hi;
      wd_lo = mult_lo;
    end else if (is_div) begin
      wd_hi = div_r;
      wd_lo = div_q;
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback queue: buffers completed instructions and retires the head
// to the register file and HI/LO when it is ready.
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned OP_W     = 20,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [31:0]                mem_pc,
  input  logic [31:0]                mem_inst,
  input  logic [OP_W-1:0]            mem_out_op,
  input  logic [4:0]                 mem_dest,
  input  logic [31:0]                mem_value,
  input  logic [3:0]                 mem_be,
  input  logic                       mem_to_wb_valid,
  output logic                       wb_allowin,
  input  logic                       wb_flush,
  input  logic                       ctrl_wb_wait,
  input  logic [65:0]                mult_p,
  input  logic                       div_p_valid,
  input  logic [79:0]                div_p_data,
  output logic                       wb_valid,
  output logic [31:0]                wb_pc,
  output logic [31:0]                wb_inst,
  output logic [OP_W-1:0]            wb_out_op,
  output logic [3:0]                 wb_rf_wen,
  output logic [4:0]                 wb_rf_waddr,
  output logic [31:0]                wb_rf_wdata,
  output logic                       we_HI,
  output logic [31:0]                wd_HI,
  output logic                       we_LO,
  output logic [31:0]                wd_LO,
  output logic [31:0]                wb_pend_mask,
  output logic [$clog2(DEPTH):0]     wb_count,
  output logic [31:0]                wb_retired
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam wb_entry_t ResetEntry = '{pc: RESET_PC, default: '0};

  wb_entry_t           slots_q [DEPTH];
  logic [PtrW-1:0]     head_q, tail_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [31:0]         retired_q;
  wb_entry_t           head, entry_in;
  logic                retire, push;
  logic [PtrW-1:0]     idx;
  logic                unused;

  assign head = slots_q[head_q];

  assign entry_in = '{pc: mem_pc, inst: mem_inst, op: OP_MAX_W'(mem_out_op), dest: mem_dest,
                      value: mem_value, be: mem_be};

  assign wb_valid  = (count_q != '0);
  assign wb_pc     = head.pc;
  assign wb_inst   = head.inst;
  assign wb_out_op = head.op[OP_W-1:0];
  assign wb_count  = count_q;
  assign wb_retired = retired_q;

  assign retire = wb_valid & ~ctrl_wb_wait & (~head.op[OP_DIV] | div_p_valid) & ~wb_flush;

  assign wb_allowin = ~wb_flush & ((count_q < CntW'(DEPTH)) | retire);
  assign push       = mem_to_wb_valid & wb_allowin;

  assign wb_rf_wen   = {4{retire & head.op[OP_REGWRITE]}} & head.be;
  assign wb_rf_waddr = head.dest;
  assign wb_rf_wdata = head.value;
  assign we_HI       = retire & head.op[OP_HIWRITE];
  assign we_LO       = retire & head.op[OP_LOWRITE];

  wb_hilo_sel u_hilo_sel (
    .is_mult (head.op[OP_MULT]),
    .is_div  (head.op[OP_DIV]),
    .mult_hi (mult_p[63:32]),
    .mult_lo (mult_p[31:0]),
    .div_q   (div_p_data[DIV_Q_HI:DIV_Q_LO]),
    .div_r   (div_p_data[DIV_R_HI:DIV_R_LO]),
    .value   (head.value),
    .wd_hi   (wd_HI),
    .wd_lo   (wd_LO)
  );

  // Walk from the head over the occupied slots only; r0 never counts as pending.
  always_comb begin
    wb_pend_mask = '0;
    idx          = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && slots_q[idx].op[OP_REGWRITE] && (slots_q[idx].dest != 5'd0)) begin
        wb_pend_mask[slots_q[idx].dest] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, retire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      retired_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots_q[i] <= ResetEntry;
      end
    end else if (wb_flush) begin
      count_q <= '0;
      head_q  <= tail_q;
    end else begin
      count_q <= count_d;
      if (push) begin
        slots_q[tail_q] <= entry_in;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (retire) begin
        head_q    <= head_q + PtrW'(1);
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign unused = ^{mult_p[65:64], div_p_data[79:72], div_p_data[39:32], head.op >> OP_W};

endmodule

// File: tb/tb_wb_retire_queue.sv
// Self-checking bench for wb_retire_queue: directed scenarios plus a scoreboard
// of expected retirements compared whenever the DUT asserts a write enable.
module tb_wb_retire_queue;

  localparam logic [19:0] OP_RW   = 20'h00400;
  localparam logic [19:0] OP_LO   = 20'h00800;
  localparam logic [19:0] OP_HI   = 20'h01000;
  localparam logic [19:0] OP_DIV  = 20'h04000;
  localparam logic [19:0] OP_MULT = 20'h08000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_pc, mem_inst, mem_value;
  logic [19:0] mem_out_op;
  logic [4:0]  mem_dest;
  logic [3:0]  mem_be;
  logic        mem_to_wb_valid, wb_allowin, wb_flush, ctrl_wb_wait;
  logic [65:0] mult_p;
  logic        div_p_valid;
  logic [79:0] div_p_data;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_inst;
  logic [19:0] wb_out_op;
  logic [3:0]  wb_rf_wen;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        we_HI, we_LO;
  logic [31:0] wd_HI, wd_LO, wb_pend_mask, wb_retired;
  logic [1:0]  wb_count;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd_hi;
    logic [31:0] wd_lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_exp;
  int   errors = 0;
  int   checks = 0;
  logic last_push;

  wb_retire_queue #(.DEPTH(2), .OP_W(20), .RESET_PC(32'hbfc00000)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_pc          (mem_pc),
    .mem_inst        (mem_inst),
    .mem_out_op      (mem_out_op),
    .mem_dest        (mem_dest),
    .mem_value       (mem_value),
    .mem_be          (mem_be),
    .mem_to_wb_valid (mem_to_wb_valid),
    .wb_allowin      (wb_allowin),
    .wb_flush        (wb_flush),
    .ctrl_wb_wait    (ctrl_wb_wait),
    .mult_p          (mult_p),
    .div_p_valid     (div_p_valid),
    .div_p_data      (div_p_data),
    .wb_valid        (wb_valid),
    .wb_pc           (wb_pc),
    .wb_inst         (wb_inst),
    .wb_out_op       (wb_out_op),
    .wb_rf_wen       (wb_rf_wen),
    .wb_rf_waddr     (wb_rf_waddr),
    .wb_rf_wdata     (wb_rf_wdata),
    .we_HI           (we_HI),
    .wd_HI           (wd_HI),
    .we_LO           (we_LO),
    .wd_LO           (wd_LO),
    .wb_pend_mask    (wb_pend_mask),
    .wb_count        (wb_count),
    .wb_retired      (wb_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Present one entry upstream and record what its retirement must look like.
  task automatic drive(input logic [19:0] op, input logic [4:0] dest, input logic [31:0] val,
                       input logic [3:0] be, input logic [31:0] ehi, input logic [31:0] elo);
    mem_pc          = 32'h8000_0000 + {22'd0, dest, 5'd0};
    mem_inst        = {12'h0ab, dest, 15'h0};
    mem_out_op      = op;
    mem_dest        = dest;
    mem_value       = val;
    mem_be          = be;
    mem_to_wb_valid = 1'b1;
    pend_exp.waddr  = dest;
    pend_exp.wdata  = val;
    pend_exp.wen    = op[10] ? be : 4'h0;
    pend_exp.we_hi  = op[12];
    pend_exp.we_lo  = op[11];
    pend_exp.wd_hi  = ehi;
    pend_exp.wd_lo  = elo;
  endtask

  // Called from a negedge: sample, score retirements and accepted pushes, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (wb_rf_wen != 4'h0 || we_HI || we_LO) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected got wen=%h waddr=%0d hi=%b lo=%b, required no write",
                 wb_rf_wen, wb_rf_waddr, we_HI, we_LO);
      end else begin
        e = exp_q.pop_front();
        if ({wb_rf_wen, wb_rf_waddr, wb_rf_wdata, we_HI, we_LO, wd_HI, wd_LO} !==
            {e.wen, e.waddr, e.wdata, e.we_hi, e.we_lo, e.wd_hi, e.wd_lo}) begin
          errors++;
          $display("FAIL retire_data got wen=%h waddr=%0d wdata=%h hi=%b/%h lo=%b/%h, required wen=%h waddr=%0d wdata=%h hi=%b/%h lo=%b/%h",
                   wb_rf_wen, wb_rf_waddr, wb_rf_wdata, we_HI, wd_HI, we_LO, wd_LO,
                   e.wen, e.waddr, e.wdata, e.we_hi, e.wd_hi, e.we_lo, e.wd_lo);
        end
      end
    end
    last_push = mem_to_wb_valid && wb_allowin;
    if (last_push) exp_q.push_back(pend_exp);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    mem_to_wb_valid = 1'b0;
    ctrl_wb_wait    = 1'b0;
    while ((exp_q.size() != 0 || wb_count != 2'd0) && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || wb_count != 2'd0) begin
      errors++;
      $display("FAIL drain got count=%0d pending=%0d, required 0/0", wb_count, exp_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; mem_to_wb_valid = 1'b0; wb_flush = 1'b0; ctrl_wb_wait = 1'b0;
    mult_p = '0; div_p_valid = 1'b0; div_p_data = '0;
    drive(OP_RW, 5'd0, 32'd0, 4'h0, 32'd0, 32'd0);
    mem_to_wb_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({wb_pc, wb_valid, wb_rf_wen, wb_count, wb_pend_mask, wb_retired, we_HI, we_LO} !==
        {32'hbfc00000, 1'b0, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got pc=%h valid=%b wen=%h count=%0d mask=%h retired=%0d, required bfc00000/0/0/0/0/0",
               wb_pc, wb_valid, wb_rf_wen, wb_count, wb_pend_mask, wb_retired);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (wb_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_allowin got %b required 1", wb_allowin);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    drive(OP_RW, 5'd5, 32'h1234, 4'hf, 32'h1234, 32'h1234);
    cycle();
    mem_to_wb_valid = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_rf_wen, wb_rf_waddr, wb_rf_wdata, wb_retired, wb_pc} !==
        {1'b1, 4'hf, 5'd5, 32'h1234, 32'd0, 32'h800000a0}) begin
      errors++;
      $display("FAIL single got valid=%b wen=%h waddr=%0d wdata=%h retired=%0d pc=%h, required 1/f/5/1234/0/800000a0",
               wb_valid, wb_rf_wen, wb_rf_waddr, wb_rf_wdata, wb_retired, wb_pc);
    end
    cycle();
    checks++;
    if ({wb_retired, wb_count} !== {32'd1, 2'd0}) begin
      errors++;
      $display("FAIL single_retired got retired=%0d count=%0d, required 1/0", wb_retired, wb_count);
    end
  endtask

  task automatic test_fill_stall();
    ctrl_wb_wait = 1'b1;
    drive(OP_RW, 5'd1, 32'h11, 4'hf, 32'h11, 32'h11);
    cycle();
    drive(OP_RW, 5'd2, 32'h22, 4'hf, 32'h22, 32'h22);
    cycle();
    drive(OP_RW, 5'd6, 32'h66, 4'hf, 32'h66, 32'h66);
    #1;
    checks++;
    if ({wb_allowin, wb_count, wb_pend_mask} !== {1'b0, 2'd2, 32'h6}) begin
      errors++;
      $display("FAIL full got allowin=%b count=%0d mask=%h, required 0/2/00000006",
               wb_allowin, wb_count, wb_pend_mask);
    end
    cycle();
    checks++;
    if (wb_count !== 2'd2) begin
      errors++;
      $display("FAIL full_hold got count=%0d required 2", wb_count);
    end
    ctrl_wb_wait = 1'b0;
    #1;
    checks++;
    if (wb_allowin !== 1'b1) begin
      errors++;
      $display("FAIL full_retire_allowin got %b required 1", wb_allowin);
    end
    cycle();
    mem_to_wb_valid = 1'b0;
    checks++;
    if (wb_count !== 2'd2) begin
      errors++;
      $display("FAIL push_retire_count got %0d required 2", wb_count);
    end
    drain();
  endtask

  task automatic test_div_wait();
    drive(OP_DIV | OP_HI | OP_LO, 5'd7, 32'hdead, 4'hf, 32'd2, 32'd7);
    cycle();
    mem_to_wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({wb_valid, we_HI, we_LO, wb_rf_wen} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
        errors++;
        $display("FAIL div_wait cycle %0d got valid=%b hi=%b lo=%b wen=%h, required 1/0/0/0",
                 k, wb_valid, we_HI, we_LO, wb_rf_wen);
      end
      cycle();
    end
    div_p_valid = 1'b1;
    div_p_data  = '0;
    div_p_data[71:40] = 32'd7;
    div_p_data[31:0]  = 32'd2;
    cycle();
    div_p_valid = 1'b0;
    checks++;
    if (wb_count !== 2'd0) begin
      errors++;
      $display("FAIL div_done got count=%0d required 0", wb_count);
    end
    mult_p = {2'b11, 32'haaaa0001, 32'h55550002};
    drive(OP_MULT | OP_HI | OP_LO, 5'd8, 32'h77, 4'hf, 32'haaaa0001, 32'h55550002);
    cycle();
    drain();
    mult_p = '0;
  endtask

  task automatic test_flush();
    logic [31:0] ret_before;
    ctrl_wb_wait = 1'b1;
    drive(OP_RW, 5'd3, 32'h33, 4'hf, 32'h33, 32'h33);
    cycle();
    drive(OP_RW, 5'd4, 32'h44, 4'hf, 32'h44, 32'h44);
    cycle();
    mem_to_wb_valid = 1'b0;
    #1;
    checks++;
    if (wb_pend_mask !== 32'h18) begin
      errors++;
      $display("FAIL flush_mask got %h required 00000018", wb_pend_mask);
    end
    ret_before   = wb_retired;
    ctrl_wb_wait = 1'b0;
    wb_flush     = 1'b1;
    drive(OP_RW, 5'd12, 32'hcc, 4'hf, 32'hcc, 32'hcc);
    #1;
    checks++;
    if ({wb_allowin, wb_rf_wen, we_HI, we_LO} !== {1'b0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_cycle got allowin=%b wen=%h hi=%b lo=%b, required 0/0/0/0",
               wb_allowin, wb_rf_wen, we_HI, we_LO);
    end
    cycle();
    wb_flush = 1'b0;
    mem_to_wb_valid = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({wb_count, wb_pend_mask, wb_valid, wb_retired} !== {2'd0, 32'h0, 1'b0, ret_before}) begin
      errors++;
      $display("FAIL flush_after got count=%0d mask=%h valid=%b retired=%0d, required 0/0/0/%0d",
               wb_count, wb_pend_mask, wb_valid, wb_retired, ret_before);
    end
    drive(OP_RW, 5'd13, 32'hdd, 4'hf, 32'hdd, 32'hdd);
    cycle();
    drain();
  endtask

  task automatic test_partial();
    drive(OP_RW, 5'd9, 32'hcafef00d, 4'b0011, 32'hcafef00d, 32'hcafef00d);
    cycle();
    mem_to_wb_valid = 1'b0;
    #1;
    checks++;
    if (wb_rf_wen !== 4'b0011) begin
      errors++;
      $display("FAIL partial_wen got %b required 0011", wb_rf_wen);
    end
    drain();
    ctrl_wb_wait = 1'b1;
    drive(OP_RW, 5'd0, 32'h1, 4'hf, 32'h1, 32'h1);
    cycle();
    mem_to_wb_valid = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_pend_mask} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL r0_mask got valid=%b mask=%h required 1/00000000", wb_valid, wb_pend_mask);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  d;
    logic [31:0] v;
    logic [3:0]  b;
    int          n;
    for (int k = 0; k < 10; k++) begin
      d = 5'($urandom_range(1, 31));
      v = $urandom;
      b = 4'($urandom_range(1, 15));
      drive(OP_RW, d, v, b, v, v);
      n = 0;
      do begin
        ctrl_wb_wait = ($urandom_range(0, 3) == 0);
        cycle();
        n++;
      end while (!last_push && n < 20);
      checks++;
      if (!last_push) begin
        errors++;
        $display("FAIL b2b_accept item %0d got no accept, required accept within 20 cycles", k);
      end
    end
    drain();
  endtask

  task automatic test_mid_reset();
    ctrl_wb_wait = 1'b1;
    drive(OP_RW, 5'd20, 32'h20, 4'hf, 32'h20, 32'h20);
    cycle();
    mem_to_wb_valid = 1'b0;
    ctrl_wb_wait    = 1'b0;
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({wb_count, wb_valid, wb_rf_wen, we_HI, we_LO, wb_retired} !==
        {2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL mid_reset got count=%0d valid=%b wen=%h retired=%0d, required 0/0/0/0",
               wb_count, wb_valid, wb_rf_wen, wb_retired);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    force dut.retired_q = 32'hffffffff;
    #1;
    release dut.retired_q;
    #1;
    checks++;
    if (wb_retired !== 32'hffffffff) begin
      errors++;
      $display("FAIL wrap_preload got %h required ffffffff", wb_retired);
    end
    @(negedge clk);
    drive(OP_RW, 5'd10, 32'haa, 4'hf, 32'haa, 32'haa);
    cycle();
    mem_to_wb_valid = 1'b0;
    cycle();
    checks++;
    if (wb_retired !== 32'd0) begin
      errors++;
      $display("FAIL wrap got %h required 00000000", wb_retired);
    end
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_stall();
    test_div_wait();
    test_flush();
    test_partial();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue.md
Name: wb_retire_queue

Overview:
- Parametrised successor to the single-entry writeback stage.
- Sits between the memory stage and the register file / HI-LO unit, and buffers up to DEPTH completed instructions in program order.
- Retires the head instruction only when it is ready: no external wait, and, for a divide, a valid divider result.
- Adds four things the single-entry stage lacks: per-entry byte-enable writes, a synchronous flush, a pending-destination scoreboard mask for hazard logic, and a retire counter.

Parameters:
- DEPTH, 2, number of queue entries; power of 2, ≥2.
- OP_W, 20, width of the decoded op vector.
- RESET_PC, 32'hbfc00000, PC value loaded into every slot at reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- mem_pc  in  32  PC from the memory stage.
- mem_inst  in  32  instruction word from the memory stage.
- mem_out_op  in  OP_W  decoded op vector.
- mem_dest  in  5  destination register.
- mem_value  in  32  result value.
- mem_be  in  4  register-file byte enables, for partial loads.
- mem_to_wb_valid  in  1  upstream valid.
- wb_allowin  out  1  queue can accept an entry this cycle.
- wb_flush  in  1  discard all queued entries.
- ctrl_wb_wait  in  1  stall retirement.
- mult_p  in  66  multiplier product; LO=[31:0], HI=[63:32].
- div_p_valid  in  1  divider result valid.
- div_p_data  in  80  divider result; quotient=[71:40], remainder=[31:0].
- wb_valid  out  1  head entry valid (queue not empty).
- wb_pc  out  32  PC of the head entry.
- wb_inst  out  32  instruction of the head entry.
- wb_out_op  out  OP_W  op vector of the head entry.
- wb_rf_wen  out  4  register-file byte write enables.
- wb_rf_waddr  out  5  register-file write address.
- wb_rf_wdata  out  32  register-file write data.
- we_HI  out  1  HI write enable.
- wd_HI  out  32  HI write data.
- we_LO  out  1  LO write enable.
- wd_LO  out  32  LO write data.
- wb_pend_mask  out  32  bit r set if any valid entry has RegWrite with dest r, r≠0.
- wb_count  out  $clog2(DEPTH)+1  number of occupied entries.
- wb_retired  out  32  count of retired instructions; wraps.

Behaviour:
- Circular buffer with head/tail pointers and an occupancy count. All state resets asynchronously on resetn low:
  - count=0, pointers=0, wb_retired=0;
  - every slot: pc=RESET_PC, inst/op/dest/value/be=0.
- With the queue empty, every write enable and wb_pend_mask are 0.
- Op bits, taken from the head entry: Mult=15, Div=14, HIWrite=12, LOWrite=11, RegWrite=10.
- ready_go = wb_valid & !ctrl_wb_wait & (!Div | div_p_valid) & !wb_flush.
- retire = ready_go. This is the only cycle in which any write enable may be asserted:
  - wb_rf_wen = {4{retire & RegWrite}} & head.be;
  - we_HI = retire & HIWrite;
  - we_LO = retire & LOWrite.
- HI/LO data:
  - wd_HI = Mult ? mult_p[63:32] : Div ? div_p_data[31:0] : value.
  - wd_LO = Mult ? mult_p[31:0] : Div ? div_p_data[71:40] : value.
- wb_rf_waddr = head.dest and wb_rf_wdata = head.value at all times, even when wb_rf_wen=0.
- wb_allowin = !wb_flush & (count<DEPTH | retire). Pushing into a full queue is therefore allowed in a cycle where the head retires.
- push = mem_to_wb_valid & wb_allowin. Push writes the tail slot at the clock edge; the pushed entry is visible at the head no earlier than the next cycle. There is no same-cycle bypass.
- Simultaneous push and retire: count is unchanged and both pointers advance.
- wb_flush, synchronous and highest priority:
  - same cycle: no writes, no push, allowin=0;
  - next edge: count=0 and head=tail. Slot contents are not cleared. wb_retired is not incremented.
- wb_retired increments by 1 on each retire and wraps from 32'hffffffff to 0.
- wb_pend_mask is combinational over the valid slots and includes the head entry.
- Reset asserted mid-operation discards all entries; no write enable asserts while resetn=0.

Decomposition:
- Package wb_pkg holds:
  - op bit index constants (OP_MULT=15, OP_DIV=14, OP_HIWRITE=12, OP_LOWRITE=11, OP_REGWRITE=10);
  - divider field constants (DIV_Q_HI=71, DIV_Q_LO=40, DIV_R_HI=31, DIV_R_LO=0);
  - the entry struct {pc, inst, op, dest, value, be}.
- One natural sub-module, wb_hilo_sel: combinational wd_HI/wd_LO selection. Everything else stays in the top module.

Test Plan:
- Reset/empty: after reset, wb_pc=32'hbfc00000, wb_valid=0, wb_rf_wen=0, wb_count=0, wb_pend_mask=0.
- Single RegWrite push:
  - stimulus: dest=5, value=32'h1234, be=4'hf;
  - response: the next cycle wb_rf_wen=4'hf, waddr=5, wdata=32'h1234; wb_retired goes 0→1.
- Fill and stall, DEPTH=2:
  - stimulus: 3 pushes with ctrl_wb_wait=1;
  - response: wb_allowin=0 after 2 pushes and wb_count=2. With wait released, retire and push occur in the same cycle and wb_count stays 2.
- Divide wait:
  - stimulus: head has Div|HIWrite|LOWrite; div_p_valid=0 for 3 cycles, then div_p_data{q=7 at [71:40], r=2 at [31:0]};
  - response: no writes for 3 cycles, then wd_LO=7, wd_HI=2 and we_HI=we_LO=1 for one cycle.
- Flush:
  - stimulus: queue holds 2 RegWrite entries (dest 3, 4), then wb_flush=1;
  - response: wb_pend_mask=32'h18 before the flush; in the flush cycle no wen and no push; the next cycle wb_count=0 and wb_pend_mask=0.
- Partial write:
  - stimulus: be=4'b0011, dest=9;
  - response: wb_rf_wen=4'b0011. Also check wb_retired wraps from 32'hffffffff to 0.
